// File: rtl/minibyte_io_responder_pkg.sv
// Shared definitions for the minibyte I/O responder.
// Holds the default base address of the 8-byte register window, the
// register offsets inside that window, and the encoding of the serial
// transmitter state machine.
package minibyte_pkg;

  localparam logic [6:0] DEFAULT_BASE_ADDR = 7'h70;

  localparam logic [2:0] OFF_TXDATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_TIMER    = 3'd2;
  localparam logic [2:0] OFF_PRESCALE = 3'd3;
  localparam logic [2:0] OFF_SCRATCH0 = 3'd4;
  localparam logic [2:0] OFF_SCRATCH1 = 3'd5;
  localparam logic [2:0] OFF_SCRATCH2 = 3'd6;
  localparam logic [2:0] OFF_SCRATCH3 = 3'd7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/minibyte_io_responder_if.sv
// CPU-side bus of the minibyte I/O responder.
//   addr_in   : 7-bit CPU address
//   data_in   : 8-bit CPU write data
//   we_in     : CPU write enable (level; the responder edge-detects it)
//   data_out  : 8-bit read data towards the CPU input mux
//   drive_out : high while data_out carries valid read data
// The master modport is the CPU side, the slave modport the responder.
interface minibyte_io_responder_if;

  logic [6:0] addr_in;
  logic [7:0] data_in;
  logic       we_in;
  logic [7:0] data_out;
  logic       drive_out;

  modport master (
    output addr_in,
    output data_in,
    output we_in,
    input  data_out,
    input  drive_out
  );

  modport slave (
    input  addr_in,
    input  data_in,
    input  we_in,
    output data_out,
    output drive_out
  );

endinterface

// File: rtl/minibyte_io_responder_uart_tx.sv
// 8N1 serial transmitter for the minibyte I/O responder.
//   clk_in : clock, all state changes on the rising edge
//   rst_in : asynchronous active-high reset, aborts any frame in flight
//   start  : one-cycle request to send 'data'; only honoured while idle
//   data   : byte to send, captured on the accepting edge
//   busy   : high from the cycle after acceptance until the stop bit ends
//   tx_out : serial line, idle high
// A frame is start bit, 8 data bits LSB first, stop bit, each held for
// CLKS_PER_BIT clocks.
module minibyte_uart_tx
  import minibyte_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx_out
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  tx_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       bit_done;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // tx_out is decoded from the state register so that reset forces the
  // line high at once, without waiting for a clock edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_out   = 1'b1;
    busy     = (state_q != TX_IDLE);
    bit_done = (cnt_q == LAST_CNT);
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_START;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = data;
        end
      end
      TX_START: begin
        tx_out = 1'b0;
        if (bit_done) begin
          cnt_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TX_DATA: begin
        tx_out = shift_q[0];
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TX_STOP: begin
        tx_out = 1'b1;
        if (bit_done) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/minibyte_io_responder.sv
// Memory-mapped I/O responder: an 8-byte register window on the minibyte
// CPU bus with a serial transmitter, a prescaled 8-bit timer with sticky
// overflow flag, and four scratch registers.
//   clk_in : clock, all state on the rising edge
//   rst_in : asynchronous active-high reset
//   bus    : CPU bus (slave side): addr_in, data_in, we_in, data_out, drive_out
//   tx_out : serial 8N1 transmit line, idle high
// Map by offset: 0 TXDATA, 1 STATUS {6'b0, tmr_ovf, tx_busy}, 2 TIMER,
// 3 PRESCALE, 4-7 SCRATCH0-3.
module minibyte_io_responder
  import minibyte_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int         CLKS_PER_BIT = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  minibyte_io_responder_if.slave  bus,
  output logic                    tx_out
);

  logic       sel;
  logic [2:0] offset;
  logic       we_q;
  logic       wr;
  logic       wr_txdata, wr_status, wr_timer, wr_prescale, wr_scratch;
  logic       tx_start, tx_busy;
  logic       tick, ovf_set, ovf_clr;

  logic [7:0] tx_data_q;
  logic [7:0] tmr_q;
  logic [7:0] prescale_q;
  logic [7:0] pre_cnt_q;
  logic       tmr_ovf_q;
  logic [7:0] scratch_q [4];

  assign sel    = (bus.addr_in[6:3] == BASE_ADDR[6:3]);
  assign offset = bus.addr_in[2:0];

  // Only the rising edge of we_in produces a write, so a CPU that holds
  // WE for several cycles still commits exactly once.
  assign wr          = sel & bus.we_in & ~we_q;
  assign wr_txdata   = wr & (offset == OFF_TXDATA);
  assign wr_status   = wr & (offset == OFF_STATUS);
  assign wr_timer    = wr & (offset == OFF_TIMER);
  assign wr_prescale = wr & (offset == OFF_PRESCALE);
  assign wr_scratch  = wr & offset[2];

  // A TXDATA write while busy is dropped entirely, including the register.
  assign tx_start = wr_txdata & ~tx_busy;

  assign tick = (pre_cnt_q == prescale_q);

  // A TIMER load in the same cycle as a wrapping tick takes precedence,
  // so that tick cannot raise the overflow flag either.
  assign ovf_set = tick & (tmr_q == 8'hFF) & ~wr_timer;
  assign ovf_clr = wr_status & bus.data_in[1];

  // Register file, prescaler and timer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      we_q       <= 1'b0;
      tx_data_q  <= '0;
      tmr_q      <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      tmr_ovf_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        scratch_q[i] <= '0;
      end
    end else begin
      we_q <= bus.we_in;

      if (tx_start) begin
        tx_data_q <= bus.data_in;
      end

      if (wr_prescale) begin
        prescale_q <= bus.data_in;
      end

      if (wr_prescale || tick) begin
        pre_cnt_q <= '0;
      end else begin
        pre_cnt_q <= pre_cnt_q + 8'd1;
      end

      if (wr_timer) begin
        tmr_q <= bus.data_in;
      end else if (tick) begin
        tmr_q <= tmr_q + 8'd1;
      end

      // Setting beats a simultaneous clear so an overflow is never lost.
      if (ovf_set) begin
        tmr_ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        tmr_ovf_q <= 1'b0;
      end

      if (wr_scratch) begin
        scratch_q[offset[1:0]] <= bus.data_in;
      end
    end
  end

  // Combinational read mux; drives only for a selected read.
  always_comb begin
    bus.data_out  = 8'h00;
    bus.drive_out = 1'b0;
    if (sel && !bus.we_in) begin
      bus.drive_out = 1'b1;
      case (offset)
        OFF_TXDATA:   bus.data_out = tx_data_q;
        OFF_STATUS:   bus.data_out = {6'b0, tmr_ovf_q, tx_busy};
        OFF_TIMER:    bus.data_out = tmr_q;
        OFF_PRESCALE: bus.data_out = prescale_q;
        default:      bus.data_out = scratch_q[offset[1:0]];
      endcase
    end
  end

  minibyte_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .start  (tx_start),
    .data   (bus.data_in),
    .busy   (tx_busy),
    .tx_out (tx_out)
  );

endmodule

// File: tb/tb_minibyte_io_responder.sv
// Directed testbench for minibyte_io_responder (CLKS_PER_BIT = 16).
// Inputs are driven 1 ns after the rising edge; outputs are sampled
// 1 ns or more after the edge, never on it.
module tb_minibyte_io_responder;
  import minibyte_pkg::*;

  localparam logic [6:0] BASE = 7'h70;
  localparam int         CPB  = 16;

  logic clk_in;
  logic rst_in;
  logic tx_out;

  int checks;
  int errors;

  minibyte_io_responder_if bus ();

  minibyte_io_responder #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus),
    .tx_out (tx_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Overall time limit so a stuck run still terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d,
                               input logic w);
    bus.addr_in = a;
    bus.data_in = d;
    bus.we_in   = w;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // One-cycle write; commits on the next rising edge, returns 1 ns later.
  task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
    applyStimulus(a, d, 1'b1);
    @(posedge clk_in);
    #1;
    applyStimulus(a, d, 1'b0);
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [7:0] d,
                          output logic drv);
    applyStimulus(BASE + {4'b0, off}, 8'h00, 1'b0);
    #1;
    d   = bus.data_out;
    drv = bus.drive_out;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] off,
                           input logic [7:0] expected);
    logic [7:0] d;
    logic       drv;
    bus_read(off, d, drv);
    checkOutput(tag, d, expected);
  endtask

  task automatic check_busy(input string tag, input logic expected);
    logic [7:0] d;
    logic       drv;
    bus_read(OFF_STATUS, d, drv);
    checkOutput(tag, {7'b0, d[0]}, {7'b0, expected});
  endtask

  // Called 1 ns after the edge that accepted the TXDATA write. Samples each
  // bit in its middle; optionally tries to overwrite TXDATA during bit 3.
  task automatic check_frame(input logic [7:0] frame_byte, input bit inject,
                             input string name);
    logic exp_bit;
    check_busy({name, "_busy_start"}, 1'b1);
    for (int k = 0; k < 10; k++) begin
      wait_cycles(CPB / 2);
      if (k == 0)      exp_bit = 1'b0;
      else if (k == 9) exp_bit = 1'b1;
      else             exp_bit = frame_byte[k-1];
      checkOutput($sformatf("%s_bit%0d", name, k), {7'b0, tx_out}, {7'b0, exp_bit});
      if (k == 9) check_busy({name, "_busy_stop"}, 1'b1);
      if (inject && k == 3) begin
        bus_write(BASE + 7'(OFF_TXDATA), 8'h3C);
        wait_cycles(CPB / 2 - 1);
      end else begin
        wait_cycles(CPB / 2);
      end
    end
    check_busy({name, "_busy_end"}, 1'b0);
    check_reg({name, "_txdata"}, OFF_TXDATA, frame_byte);
  endtask

  initial begin
    logic [7:0] d;
    logic       drv;
    int         zero_count;

    checks = 0;
    errors = 0;
    rst_in = 1'b1;
    applyStimulus(7'h00, 8'h00, 1'b0);

    // Reset state, read while reset is still asserted.
    #2;
    checkOutput("rst_tx_out", {7'b0, tx_out}, 8'h01);
    bus_read(3'd0, d, drv);
    checkOutput("rst_txdata", d, 8'h00);
    check_reg("rst_status", OFF_STATUS, 8'h00);
    check_reg("rst_timer", OFF_TIMER, 8'h00);
    check_reg("rst_scratch3", OFF_SCRATCH3, 8'h00);
    applyStimulus(7'h10, 8'h00, 1'b0);
    #1;
    checkOutput("rst_out_of_window_drive", {7'b0, bus.drive_out}, 8'h00);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    wait_cycles(2);

    // Frame 0xA5 with an ignored mid-frame write of 0x3C.
    bus_write(BASE + 7'(OFF_TXDATA), 8'hA5);
    check_frame(8'hA5, 1'b1, "frameA5");

    // Write landing on the last STOP cycle is dropped; a later one is taken.
    bus_write(BASE + 7'(OFF_TXDATA), 8'h5A);
    wait_cycles(10 * CPB - 1);
    check_busy("stop_last_busy", 1'b1);
    bus_write(BASE + 7'(OFF_TXDATA), 8'hC3);
    check_busy("stop_end_busy", 1'b0);
    check_reg("stop_end_txdata", OFF_TXDATA, 8'h5A);
    wait_cycles(1);
    bus_write(BASE + 7'(OFF_TXDATA), 8'hC3);
    check_busy("after_stop_busy", 1'b1);
    check_reg("after_stop_txdata", OFF_TXDATA, 8'hC3);
    wait_cycles(10 * CPB + 10);

    // Timer: PRESCALE = 3, TIMER = 0xFE loaded on a wrapping tick.
    bus_write(BASE + 7'(OFF_PRESCALE), 8'h03);
    wait_cycles(3);
    bus_write(BASE + 7'(OFF_TIMER), 8'hFE);
    check_reg("tmr_loaded", OFF_TIMER, 8'hFE);
    wait_cycles(3);
    check_reg("tmr_before_tick", OFF_TIMER, 8'hFE);
    wait_cycles(1);
    check_reg("tmr_after_4", OFF_TIMER, 8'hFF);
    wait_cycles(4);
    check_reg("tmr_after_8", OFF_TIMER, 8'h00);
    check_reg("status_ovf", OFF_STATUS, 8'h02);
    bus_write(BASE + 7'(OFF_STATUS), 8'h02);
    check_reg("status_cleared", OFF_STATUS, 8'h00);
    check_reg("prescale_rd", OFF_PRESCALE, 8'h03);

    // Overflow and STATUS clear on the same edge: overflow wins.
    wait_cycles(2);
    bus_write(BASE + 7'(OFF_TIMER), 8'hFF);
    wait_cycles(3);
    bus_write(BASE + 7'(OFF_STATUS), 8'h02);
    check_reg("ovf_vs_clear_status", OFF_STATUS, 8'h02);
    check_reg("ovf_vs_clear_timer", OFF_TIMER, 8'h00);

    // Scratch registers and a same-cycle combinational read.
    wait_cycles(1);
    bus_write(BASE + 7'(OFF_SCRATCH0), 8'h12);
    wait_cycles(1);
    bus_write(BASE + 7'(OFF_SCRATCH1), 8'h34);
    wait_cycles(1);
    bus_write(BASE + 7'(OFF_SCRATCH3), 8'h78);
    wait_cycles(1);
    bus_write(BASE + 7'(OFF_SCRATCH2), 8'h9B);
    applyStimulus(7'h76, 8'h00, 1'b0);
    #1;
    checkOutput("scratch2_data", bus.data_out, 8'h9B);
    checkOutput("scratch2_drive", {7'b0, bus.drive_out}, 8'h01);
    wait_cycles(1);

    // WE held for 5 cycles on TXDATA: exactly one frame.
    applyStimulus(BASE + 7'(OFF_TXDATA), 8'h11, 1'b1);
    @(posedge clk_in);
    #1;
    zero_count = 0;
    for (int i = 0; i < 400; i++) begin
      if (tx_out == 1'b0) zero_count++;
      if (i == 3) applyStimulus(BASE + 7'(OFF_TXDATA), 8'h11, 1'b0);
      wait_cycles(1);
    end
    // 0x11 has six zero data bits plus the start bit, 16 clocks each.
    checkOutput("held_we_zero_cycles", 8'(zero_count), 8'd112);
    check_reg("held_we_txdata", OFF_TXDATA, 8'h11);

    // WE held for 5 cycles on TIMER with PRESCALE = 0: one load, then counts.
    bus_write(BASE + 7'(OFF_PRESCALE), 8'h00);
    wait_cycles(1);
    applyStimulus(BASE + 7'(OFF_TIMER), 8'h40, 1'b1);
    repeat (5) @(posedge clk_in);
    #1;
    applyStimulus(BASE + 7'(OFF_TIMER), 8'h40, 1'b0);
    check_reg("held_we_timer", OFF_TIMER, 8'h44);
    wait_cycles(1);

    // Out-of-window write leaves everything alone and is never driven.
    bus_write(7'h7C, 8'h55);
    applyStimulus(7'h7C, 8'h00, 1'b0);
    #1;
    checkOutput("outside_drive", {7'b0, bus.drive_out}, 8'h00);
    checkOutput("outside_data", bus.data_out, 8'h00);
    check_reg("outside_scratch0", OFF_SCRATCH0, 8'h12);
    check_reg("outside_scratch1", OFF_SCRATCH1, 8'h34);
    wait_cycles(1);
    check_reg("outside_scratch2", OFF_SCRATCH2, 8'h9B);
    check_reg("outside_scratch3", OFF_SCRATCH3, 8'h78);
    check_reg("outside_txdata", OFF_TXDATA, 8'h11);
    check_reg("outside_prescale", OFF_PRESCALE, 8'h00);
    wait_cycles(1);

    // Reset in the middle of data bit 4 of 0x6E (bit 4 is 0).
    bus_write(BASE + 7'(OFF_TXDATA), 8'h6E);
    wait_cycles(5 * CPB + CPB / 2 - 1);
    checkOutput("pre_reset_bit4", {7'b0, tx_out}, 8'h00);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("reset_tx_immediate", {7'b0, tx_out}, 8'h01);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check_reg("post_reset_status", OFF_STATUS, 8'h00);
    check_reg("post_reset_scratch0", OFF_SCRATCH0, 8'h00);
    check_reg("post_reset_txdata", OFF_TXDATA, 8'h00);
    bus_write(BASE + 7'(OFF_SCRATCH1), 8'hE7);
    check_reg("first_edge_write", OFF_SCRATCH1, 8'hE7);
    zero_count = 0;
    for (int i = 0; i < 200; i++) begin
      if (tx_out == 1'b0) zero_count++;
      wait_cycles(1);
    end
    checkOutput("no_frame_resumed", 8'(zero_count), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/minibyte_io_responder.md
MINIBYTE_IO_RESPONDER -- requirements
Module: minibyte_io_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 7'h70, base of an 8-byte window (0x70-0x77), clear of onboard reg RAM at 0x7C-0x7F.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clocks per serial bit, legal range 2-255.
REQ-003 SHALL have port clk_in  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port addr_in  input  7  CPU address bus.
REQ-006 SHALL have port data_in  input  8  CPU write data.
REQ-007 SHALL have port we_in  input  1  CPU write enable.
REQ-008 SHALL have port data_out  output  8  read data to CPU input mux.
REQ-009 SHALL have port drive_out  output  1  high when data_out carries valid read data.
REQ-010 SHALL have port tx_out  output  1  serial 8N1 transmit line, idle high.

Function
REQ-011 sel = addr_in[6:3] == BASE_ADDR[6:3]; offset = addr_in[2:0].
REQ-012 Register map by offset: 0 TXDATA, 1 STATUS, 2 TIMER, 3 PRESCALE, 4-7 SCRATCH0-3.
REQ-013 Read path SHALL be combinational: sel & !we_in -> data_out = register at offset, drive_out = 1; otherwise data_out = 0x00, drive_out = 0.
REQ-014 Write strobe wr = sel & we_in & !we_q, where we_q is we_in registered; a WE held over several cycles commits exactly once.
REQ-015 Writes SHALL take effect on the clk_in edge at which wr is high; the new value is readable the next cycle.
REQ-016 TXDATA write while tx idle: latch data, start a frame; busy reads 1 from the next cycle.
REQ-017 TXDATA write while busy: ignored completely (register, shifter and frame unchanged).
REQ-018 TXDATA read returns the last accepted byte.
REQ-019 TX FSM states IDLE -> START -> DATA -> STOP -> IDLE; each state bit lasts CLKS_PER_BIT cycles; DATA sends 8 bits LSB first.
REQ-020 tx_out: 1 in IDLE and STOP, 0 in START, data bit in DATA; frame = 10*CLKS_PER_BIT cycles.
REQ-021 A TXDATA write in the same cycle STOP ends is ignored (busy still 1); the next cycle is accepted.
REQ-022 STATUS read: bit0 tx_busy, bit1 tmr_ovf, bits[7:2] = 0.
REQ-023 STATUS write: bit1 = 1 clears tmr_ovf; all other bits ignored.
REQ-024 Prescale counter counts 0..PRESCALE, then wraps to 0 and emits one tick; PRESCALE = 0 ticks every cycle.
REQ-025 On tick TIMER increments mod 256; 0xFF -> 0x00 sets tmr_ovf (sticky).
REQ-026 TIMER write loads data_in and overrides a same-cycle tick; the prescale counter is unaffected.
REQ-027 PRESCALE write resets the prescale counter to 0.
REQ-028 Simultaneous ovf set and STATUS clear: set wins, tmr_ovf = 1.
REQ-029 SCRATCH0-3 are plain 8-bit read/write registers.
REQ-030 Addresses outside the window SHALL never alter state.

Reset
REQ-031 rst_in high SHALL immediately force all registers to 0x00, tmr_ovf = 0, we_q = 0, prescale counter = 0, TX FSM = IDLE, tx_out = 1.
REQ-032 Reset during a frame SHALL abort it, with tx_out high and no partial frame resumed after release.
REQ-033 The first rising clk_in edge after rst_in falls SHALL be a normal functional edge.

Structure
REQ-034 Package minibyte_pkg SHALL hold the register offset constants, TX FSM state encoding and the default BASE_ADDR.
REQ-035 The serial transmitter SHALL be sub-module minibyte_uart_tx (ports: clk_in, rst_in, start, data, busy, tx_out).
REQ-036 Decode, register file, timer and read mux SHALL live in minibyte_io_responder.

Verification (CLKS_PER_BIT = 16)
REQ-037 Write 0x70 = 0xA5 -> busy = 1 next cycle; tx_out shows 0 then bits 1,0,1,0,0,1,0,1 then 1, each 16 cycles; busy = 0 after 160 cycles.
REQ-038 Write 0x70 = 0x3C mid-frame of 0xA5 -> frame is 0xA5 unchanged; TXDATA reads 0xA5.
REQ-039 PRESCALE = 3, TIMER = 0xFE -> TIMER = 0xFF after 4 cycles, 0x00 after 8 cycles, STATUS = 0x02; write STATUS = 0x02 -> STATUS = 0x00.
REQ-040 WE held 5 cycles on 0x70 = 0x11 -> exactly one frame; write 0x7C = 0x55 -> no responder state change, drive_out = 0.
REQ-041 Assert rst_in at bit 4 of a frame -> tx_out = 1 immediately; STATUS = 0x00, SCRATCH0 = 0x00 after release.
REQ-042 Write SCRATCH2 = 0x9B, read 0x76 with we_in = 0 -> data_out = 0x9B, drive_out = 1 the same cycle.
